// File: rtl/shared_mem_port.sv
// ---------------------------------------------------------------------------
// shared_mem_port
//
// One single-port RAM shared by two requesters: the CPU load/store port and a
// host (AXI-BRAM controller) port used to load the image at boot.
//
// After reset the block sits in BOOT. Only the host may access the RAM and
// the CPU is held. A boot_done_i pulse moves the block to RUN. In RUN both
// ports compete for the RAM, and a round-robin pointer settles same-cycle
// conflicts. The pointer starts on the CPU and moves away from each conflict
// winner, so the losing port is served on the very next cycle.
//
// Read data returns READ_LATENCY cycles after the grant edge. A small tag
// pipeline records which port owns each access and whether it was a read or
// an out-of-range CPU access. The final stage of that pipeline steers the
// data and drives the valid pulses.
//
// Parameters
//   ADDR_W        word-address width, RAM depth = 2**ADDR_W words
//   DATA_W        word width, must be a multiple of 8 (one write lane per byte)
//   READ_LATENCY  1 = RAM output used directly, 2 = extra output register
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   boot_done_i    host pulse: image loaded, release the CPU
//   cpu_hold_o     high while in BOOT
//   cpu_*          CPU request (byte address), stall, read data/valid, error
//   host_*         host request (word address), busy, read data/valid
// ---------------------------------------------------------------------------
module shared_mem_port #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  boot_done_i,
    output logic                  cpu_hold_o,

    input  logic                  cpu_req_i,
    input  logic [DATA_W/8-1:0]   cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [DATA_W-1:0]     cpu_wdata_i,
    output logic                  cpu_stall_o,
    output logic [DATA_W-1:0]     cpu_rdata_o,
    output logic                  cpu_rvalid_o,
    output logic                  cpu_err_o,

    input  logic                  host_en_i,
    input  logic [DATA_W/8-1:0]   host_we_i,
    input  logic [ADDR_W-1:0]     host_addr_i,
    input  logic [DATA_W-1:0]     host_wdata_i,
    output logic                  host_busy_o,
    output logic [DATA_W-1:0]     host_rdata_o,
    output logic                  host_rvalid_o
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // One entry per access in flight.
    //   rd  : the access was a read and must raise the owner's rvalid
    //   cpu : owner is the CPU port (otherwise the host)
    //   err : CPU access fell outside the RAM; RAM was not touched
    typedef struct packed {
        logic rd;
        logic cpu;
        logic err;
    } tag_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]        state_q,  state_d;
    logic              rr_ptr_q, rr_ptr_d;     // 0: CPU wins next conflict
    tag_t              tag_q [READ_LATENCY];
    tag_t              tag_d [READ_LATENCY];
    logic [DATA_W-1:0] cpu_last_q,  cpu_last_d;
    logic [DATA_W-1:0] host_last_q, host_last_d;
    logic [DATA_W-1:0] dout2_q,     dout2_d;

    // RAM and its read port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rdata_q;
    logic              ram_re;
    logic [LANES-1:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    // -----------------------------------------------------------------------
    // CPU address decode
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] cpu_word;
    logic [31:0]       cpu_addr_hi;
    logic              cpu_oor;
    logic              cpu_rd_req;
    logic              host_rd_req;
    logic              unused_addr_lsbs;

    // The CPU always issues word-aligned accesses, so the byte offset carries
    // no information here.
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    assign cpu_word    = cpu_addr_i[ADDR_W+1:2];
    assign cpu_addr_hi = cpu_addr_i >> (ADDR_W + 2);
    assign cpu_oor     = |cpu_addr_hi;
    assign cpu_rd_req  = ~|cpu_we_i;
    assign host_rd_req = ~|host_we_i;

    // -----------------------------------------------------------------------
    // Boot FSM and arbitration
    // -----------------------------------------------------------------------
    logic cpu_grant;
    logic host_grant;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first. A path that leaves one unassigned would infer a latch.
        cpu_grant  = 1'b0;
        host_grant = 1'b0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;

        case (state_q)
            ST_BOOT: begin
                // The host owns the RAM outright. A request in the same cycle
                // as boot_done_i is still served.
                host_grant = host_en_i;
                if (boot_done_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (cpu_req_i && host_en_i) begin
                    // Conflict: serve the pointed-to port, then point away from
                    // it so the held request wins the next cycle.
                    cpu_grant  = ~rr_ptr_q;
                    host_grant =  rr_ptr_q;
                    rr_ptr_d   = ~rr_ptr_q;
                end else begin
                    cpu_grant  = cpu_req_i;
                    host_grant = host_en_i;
                end
            end
        endcase
    end

    assign cpu_hold_o  = (state_q == ST_BOOT);
    assign cpu_stall_o = cpu_req_i & ~cpu_grant;
    assign host_busy_o = host_en_i & ~host_grant;

    // -----------------------------------------------------------------------
    // RAM access mux and tag pipeline input
    // -----------------------------------------------------------------------
    always_comb begin
        ram_re    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        tag_d[0]  = '0;

        if (cpu_grant) begin
            ram_addr  = cpu_word;
            ram_wdata = cpu_wdata_i;
            // An out-of-range access leaves the RAM untouched but still
            // travels down the pipeline so the error lines up with the data.
            ram_re    = cpu_rd_req & ~cpu_oor;
            ram_we    = cpu_oor ? '0 : cpu_we_i;
            tag_d[0]  = '{rd: cpu_rd_req, cpu: 1'b1, err: cpu_oor};
        end else if (host_grant) begin
            ram_addr  = host_addr_i;
            ram_wdata = host_wdata_i;
            ram_re    = host_rd_req;
            ram_we    = host_we_i;
            tag_d[0]  = '{rd: host_rd_req, cpu: 1'b0, err: 1'b0};
        end

        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // Output stage
    // -----------------------------------------------------------------------
    tag_t              tag_out;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] cpu_data_now;

    assign tag_out  = tag_q[READ_LATENCY-1];
    assign dout2_d  = ram_rdata_q;
    assign ram_data = (READ_LATENCY == 2) ? dout2_q : ram_rdata_q;

    assign cpu_rvalid_o  = tag_out.rd & tag_out.cpu;
    assign host_rvalid_o = tag_out.rd & ~tag_out.cpu;
    assign cpu_err_o     = tag_out.err;

    // A failed CPU read returns zero, not a stale RAM word.
    assign cpu_data_now = tag_out.err ? '0 : ram_data;

    // Each port keeps showing its last returned word between pulses.
    assign cpu_rdata_o  = cpu_rvalid_o  ? cpu_data_now : cpu_last_q;
    assign host_rdata_o = host_rvalid_o ? ram_data     : host_last_q;
    assign cpu_last_d   = cpu_rdata_o;
    assign host_last_d  = host_rdata_o;

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            rr_ptr_q    <= 1'b0;
            cpu_last_q  <= '0;
            host_last_q <= '0;
            // Dropping in-flight tags guarantees that no pulse emerges after
            // reset, even for an access granted just before it.
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cpu_last_q  <= cpu_last_d;
            host_last_q <= host_last_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data path registers and RAM
    // -----------------------------------------------------------------------
    // NOTE: the RAM array and its data registers have no reset. The tag
    // pipeline decides whether their contents are ever observed, and a reset
    // on the array would prevent block-RAM inference and wipe the image.
    always_ff @(posedge clk) begin
        dout2_q <= dout2_d;
    end

    // Read-first single port: the read samples the array before this edge's
    // write lands. The arbiter allows only one access per cycle anyway.
    always_ff @(posedge clk) begin
        if (ram_re) begin
            ram_rdata_q <= mem[ram_addr];
        end
        for (int i = 0; i < LANES; i++) begin
            if (ram_we[i]) begin
                mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_shared_mem_port.sv
// ---------------------------------------------------------------------------
// tb_shared_mem_port
//
// Directed bench for shared_mem_port. Instance "a" uses READ_LATENCY=1 and
// covers boot hold, byte lanes, round robin, range check and back-to-back
// reads. Instance "b" uses READ_LATENCY=2 and covers the longer latency,
// reset in the middle of a read, and the reset value of the arbiter pointer.
// Inputs are driven 1 ns after the rising edge. Registered outputs are checked
// right after the edge, and combinational outputs 1 ns after the drive.
// ---------------------------------------------------------------------------
module tb_shared_mem_port;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance a : READ_LATENCY = 1 ----------------
    logic              a_reset, a_boot_done, a_cpu_hold;
    logic              a_cpu_req, a_cpu_stall, a_cpu_rvalid, a_cpu_err;
    logic [LANES-1:0]  a_cpu_we;
    logic [31:0]       a_cpu_addr;
    logic [DATA_W-1:0] a_cpu_wdata, a_cpu_rdata;
    logic              a_host_en, a_host_busy, a_host_rvalid;
    logic [LANES-1:0]  a_host_we;
    logic [ADDR_W-1:0] a_host_addr;
    logic [DATA_W-1:0] a_host_wdata, a_host_rdata;

    shared_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) dut_a (
        .clk          (clk),
        .reset        (a_reset),
        .boot_done_i  (a_boot_done),
        .cpu_hold_o   (a_cpu_hold),
        .cpu_req_i    (a_cpu_req),
        .cpu_we_i     (a_cpu_we),
        .cpu_addr_i   (a_cpu_addr),
        .cpu_wdata_i  (a_cpu_wdata),
        .cpu_stall_o  (a_cpu_stall),
        .cpu_rdata_o  (a_cpu_rdata),
        .cpu_rvalid_o (a_cpu_rvalid),
        .cpu_err_o    (a_cpu_err),
        .host_en_i    (a_host_en),
        .host_we_i    (a_host_we),
        .host_addr_i  (a_host_addr),
        .host_wdata_i (a_host_wdata),
        .host_busy_o  (a_host_busy),
        .host_rdata_o (a_host_rdata),
        .host_rvalid_o(a_host_rvalid)
    );

    // ---------------- instance b : READ_LATENCY = 2 ----------------
    logic              b_reset, b_boot_done, b_cpu_hold;
    logic              b_cpu_req, b_cpu_stall, b_cpu_rvalid, b_cpu_err;
    logic [LANES-1:0]  b_cpu_we;
    logic [31:0]       b_cpu_addr;
    logic [DATA_W-1:0] b_cpu_wdata, b_cpu_rdata;
    logic              b_host_en, b_host_busy, b_host_rvalid;
    logic [LANES-1:0]  b_host_we;
    logic [ADDR_W-1:0] b_host_addr;
    logic [DATA_W-1:0] b_host_wdata, b_host_rdata;

    shared_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(2)) dut_b (
        .clk          (clk),
        .reset        (b_reset),
        .boot_done_i  (b_boot_done),
        .cpu_hold_o   (b_cpu_hold),
        .cpu_req_i    (b_cpu_req),
        .cpu_we_i     (b_cpu_we),
        .cpu_addr_i   (b_cpu_addr),
        .cpu_wdata_i  (b_cpu_wdata),
        .cpu_stall_o  (b_cpu_stall),
        .cpu_rdata_o  (b_cpu_rdata),
        .cpu_rvalid_o (b_cpu_rvalid),
        .cpu_err_o    (b_cpu_err),
        .host_en_i    (b_host_en),
        .host_we_i    (b_host_we),
        .host_addr_i  (b_host_addr),
        .host_wdata_i (b_host_wdata),
        .host_busy_o  (b_host_busy),
        .host_rdata_o (b_host_rdata),
        .host_rvalid_o(b_host_rvalid)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Image loaded by the host during boot.
    function automatic logic [31:0] init_word(input int k);
        case (k)
            0:       return 32'hDEAD_BEEF;
            5:       return 32'h1122_3344;
            default: return 32'h1000_0000 + 32'(k);
        endcase
    endfunction

    // Image after the CPU byte-lane write to word 5.
    function automatic logic [31:0] final_word(input int k);
        return (k == 5) ? 32'h11BB_33DD : init_word(k);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        a_reset = 1'b1; a_boot_done = 1'b0;
        a_cpu_req = 1'b0; a_cpu_we = '0; a_cpu_addr = '0; a_cpu_wdata = '0;
        a_host_en = 1'b0; a_host_we = '0; a_host_addr = '0; a_host_wdata = '0;
        b_reset = 1'b1; b_boot_done = 1'b0;
        b_cpu_req = 1'b0; b_cpu_we = '0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_host_en = 1'b0; b_host_we = '0; b_host_addr = '0; b_host_wdata = '0;
        step();
        step();

        // ---- reset values ----
        check("rst_hold",        64'(a_cpu_hold),    64'd1);
        check("rst_cpu_rvalid",  64'(a_cpu_rvalid),  64'd0);
        check("rst_host_rvalid", 64'(a_host_rvalid), 64'd0);
        check("rst_err",         64'(a_cpu_err),     64'd0);
        check("rst_cpu_rdata",   64'(a_cpu_rdata),   64'd0);
        check("rst_host_rdata",  64'(a_host_rdata),  64'd0);

        // ---- boot hold: CPU requests a read of 0x0 for 10 cycles ----
        a_reset    = 1'b0;
        a_cpu_req  = 1'b1;
        a_cpu_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("boot_hold",  64'(a_cpu_hold),  64'd1);
            check("boot_stall", 64'(a_cpu_stall), 64'd1);
            step();
        end
        check("boot_no_cpu_rvalid", 64'(a_cpu_rvalid), 64'd0);

        // ---- host loads words 0..7; boot_done_i with the last write ----
        for (int k = 0; k < 8; k++) begin
            a_host_en    = 1'b1;
            a_host_we    = 4'hF;
            a_host_addr  = ADDR_W'(k);
            a_host_wdata = init_word(k);
            a_boot_done  = (k == 7);
            #1;
            check("boot_host_busy", 64'(a_host_busy), 64'd0);
            check("boot_cpu_stall", 64'(a_cpu_stall), 64'd1);
            step();
        end
        a_host_en   = 1'b0;
        a_host_we   = '0;
        a_boot_done = 1'b0;
        #1;
        check("run_hold",           64'(a_cpu_hold),    64'd0);
        check("run_cpu_stall",      64'(a_cpu_stall),   64'd0);
        check("host_wr_no_rvalid",  64'(a_host_rvalid), 64'd0);
        step();
        a_cpu_req = 1'b0;
        check("cpu_rd0_rvalid", 64'(a_cpu_rvalid), 64'd1);
        check("cpu_rd0_data",   64'(a_cpu_rdata),  64'hDEAD_BEEF);

        // ---- byte lanes: CPU writes lanes 0 and 2 of word 5 ----
        a_cpu_req   = 1'b1;
        a_cpu_we    = 4'b0101;
        a_cpu_addr  = 32'h14;
        a_cpu_wdata = 32'hAABB_CCDD;
        step();
        a_cpu_req = 1'b0;
        a_cpu_we  = '0;
        check("cpu_wr_no_rvalid", 64'(a_cpu_rvalid), 64'd0);
        a_host_en   = 1'b1;
        a_host_addr = 15'd5;
        step();
        a_host_en = 1'b0;
        check("lane_rvalid", 64'(a_host_rvalid), 64'd1);
        check("lane_data",   64'(a_host_rdata),  64'h11BB_33DD);
        check("lane_cpu_rv", 64'(a_cpu_rvalid),  64'd0);

        // ---- round robin: both ports request for 4 cycles ----
        // c1: CPU word 1 vs host word 2 -> CPU (pointer at reset value)
        a_cpu_req = 1'b1; a_cpu_addr = 32'h4;
        a_host_en = 1'b1; a_host_addr = 15'd2;
        #1;
        check("rr1_stall", 64'(a_cpu_stall), 64'd0);
        check("rr1_busy",  64'(a_host_busy), 64'd1);
        step();
        check("rr1_cpu_rv",   64'(a_cpu_rvalid),  64'd1);
        check("rr1_cpu_data", 64'(a_cpu_rdata),   64'h1000_0001);
        check("rr1_host_rv",  64'(a_host_rvalid), 64'd0);
        // c2: CPU word 3 vs host word 2 (held) -> host
        a_cpu_addr = 32'hC;
        #1;
        check("rr2_stall", 64'(a_cpu_stall), 64'd1);
        check("rr2_busy",  64'(a_host_busy), 64'd0);
        step();
        check("rr2_host_rv",   64'(a_host_rvalid), 64'd1);
        check("rr2_host_data", 64'(a_host_rdata),  64'h1000_0002);
        check("rr2_cpu_rv",    64'(a_cpu_rvalid),  64'd0);
        // c3: CPU word 3 (held) vs host word 4 -> CPU
        a_host_addr = 15'd4;
        #1;
        check("rr3_stall", 64'(a_cpu_stall), 64'd0);
        check("rr3_busy",  64'(a_host_busy), 64'd1);
        step();
        check("rr3_cpu_rv",     64'(a_cpu_rvalid),  64'd1);
        check("rr3_cpu_data",   64'(a_cpu_rdata),   64'h1000_0003);
        check("rr3_host_rv",    64'(a_host_rvalid), 64'd0);
        check("rr3_host_hold",  64'(a_host_rdata),  64'h1000_0002);
        // c4: CPU word 6 vs host word 4 (held) -> host
        a_cpu_addr = 32'h18;
        #1;
        check("rr4_stall", 64'(a_cpu_stall), 64'd1);
        check("rr4_busy",  64'(a_host_busy), 64'd0);
        step();
        a_host_en = 1'b0;
        check("rr4_host_rv",   64'(a_host_rvalid), 64'd1);
        check("rr4_host_data", 64'(a_host_rdata),  64'h1000_0004);
        check("rr4_cpu_rv",    64'(a_cpu_rvalid),  64'd0);
        check("rr4_cpu_hold",  64'(a_cpu_rdata),   64'h1000_0003);
        // c5: CPU's held request for word 6 is now served alone
        #1;
        check("rr5_stall", 64'(a_cpu_stall), 64'd0);
        step();
        a_cpu_req = 1'b0;
        check("rr5_cpu_rv",   64'(a_cpu_rvalid), 64'd1);
        check("rr5_cpu_data", 64'(a_cpu_rdata),  64'h1000_0006);

        // ---- range check: byte address 0x0002_0000 is beyond 2^15 words ----
        a_cpu_req  = 1'b1;
        a_cpu_we   = '0;
        a_cpu_addr = 32'h0002_0000;
        step();
        check("oor_rd_err",    64'(a_cpu_err),    64'd1);
        check("oor_rd_rvalid", 64'(a_cpu_rvalid), 64'd1);
        check("oor_rd_data",   64'(a_cpu_rdata),  64'd0);
        a_cpu_we    = 4'hF;
        a_cpu_wdata = 32'h5555_5555;
        step();
        a_cpu_req = 1'b0;
        a_cpu_we  = '0;
        check("oor_wr_err",    64'(a_cpu_err),    64'd1);
        check("oor_wr_rvalid", 64'(a_cpu_rvalid), 64'd0);
        a_host_en   = 1'b1;
        a_host_addr = 15'd0;
        step();
        a_host_en = 1'b0;
        check("oor_word0_rv",   64'(a_host_rvalid), 64'd1);
        check("oor_word0_data", 64'(a_host_rdata),  64'hDEAD_BEEF);
        check("oor_err_clear",  64'(a_cpu_err),     64'd0);

        // ---- boot_done_i in RUN has no effect ----
        a_boot_done = 1'b1;
        step();
        a_boot_done = 1'b0;
        step();
        check("run_boot_done_ignored", 64'(a_cpu_hold), 64'd0);

        // ---- back-to-back host reads of words 0..7 ----
        a_host_en = 1'b1;
        a_host_we = '0;
        for (int k = 0; k < 8; k++) begin
            a_host_addr = ADDR_W'(k);
            step();
            check("b2b_rvalid", 64'(a_host_rvalid), 64'd1);
            check("b2b_data",   64'(a_host_rdata),  64'(final_word(k)));
        end
        a_host_en = 1'b0;
        step();
        check("b2b_end", 64'(a_host_rvalid), 64'd0);

        // ================= instance b : READ_LATENCY = 2 =================
        check("b_rst_hold",   64'(b_cpu_hold),   64'd1);
        check("b_rst_rvalid", 64'(b_cpu_rvalid), 64'd0);
        b_reset      = 1'b0;
        b_host_en    = 1'b1;
        b_host_we    = 4'hF;
        b_host_addr  = 15'd3;
        b_host_wdata = 32'hCAFE_F00D;
        b_boot_done  = 1'b1;
        step();
        b_host_en   = 1'b0;
        b_host_we   = '0;
        b_boot_done = 1'b0;
        check("b_run_hold", 64'(b_cpu_hold), 64'd0);

        // CPU read of word 3: data two cycles after the grant
        b_cpu_req  = 1'b1;
        b_cpu_addr = 32'hC;
        step();
        b_cpu_req = 1'b0;
        check("b_lat2_early", 64'(b_cpu_rvalid), 64'd0);
        step();
        check("b_lat2_rvalid", 64'(b_cpu_rvalid), 64'd1);
        check("b_lat2_data",   64'(b_cpu_rdata),  64'hCAFE_F00D);

        // Conflict (CPU wins, pointer moves to host), then a second CPU read
        // that is cut short by reset.
        b_cpu_req   = 1'b1;
        b_host_en   = 1'b1;
        b_host_addr = 15'd3;
        #1;
        check("b_pre_rr_stall", 64'(b_cpu_stall), 64'd0);
        check("b_pre_rr_busy",  64'(b_host_busy), 64'd1);
        step();
        b_host_en = 1'b0;
        step();
        b_cpu_req = 1'b0;
        check("b_first_rd_rv",   64'(b_cpu_rvalid), 64'd1);
        check("b_first_rd_data", 64'(b_cpu_rdata),  64'hCAFE_F00D);
        b_reset = 1'b1;
        step();
        check("b_midrst_rvalid", 64'(b_cpu_rvalid), 64'd0);
        check("b_midrst_hold",   64'(b_cpu_hold),   64'd1);
        b_reset = 1'b0;
        step();
        check("b_post_cpu_rv",  64'(b_cpu_rvalid),  64'd0);
        check("b_post_host_rv", 64'(b_host_rvalid), 64'd0);
        check("b_post_err",     64'(b_cpu_err),     64'd0);

        // RAM contents survive reset
        b_host_en   = 1'b1;
        b_host_addr = 15'd3;
        step();
        b_host_en = 1'b0;
        check("b_keep_early", 64'(b_host_rvalid), 64'd0);
        step();
        check("b_keep_rvalid", 64'(b_host_rvalid), 64'd1);
        check("b_keep_data",   64'(b_host_rdata),  64'hCAFE_F00D);

        // Pointer is back at the CPU after reset
        b_boot_done = 1'b1;
        step();
        b_boot_done = 1'b0;
        b_cpu_req   = 1'b1;
        b_cpu_addr  = 32'hC;
        b_host_en   = 1'b1;
        #1;
        check("b_rr_rst_stall", 64'(b_cpu_stall), 64'd0);
        check("b_rr_rst_busy",  64'(b_host_busy), 64'd1);
        step();
        b_cpu_req = 1'b0;
        b_host_en = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
